// File: rtl/icache_downstream_responder.sv
// Memory-side model that answers icache line refills in order after a fixed latency.
// Line data is derived from the line address so the refill path can self-check.
module icache_downstream_responder #(
    parameter int QUEUE_DEPTH = 4,
    parameter int LATENCY     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           downstream_txreq_vld,
    output logic                           downstream_txreq_rdy,
    input  logic [41:0]                    downstream_txreq_pld,
    output logic                           downstream_rxdat_vld,
    input  logic                           downstream_rxdat_rdy,
    output logic [530:0]                   downstream_rxdat_pld,
    output logic [$clog2(QUEUE_DEPTH):0]   outstanding_cnt,
    output logic                           bad_opcode_err
);

    localparam int IW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int OW = IW + 1;
    localparam logic [CW-1:0] LAT_LOAD = CW'(LATENCY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW:0]   PTR_ONE  = OW'(1);
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);

    // Only the line part of the address is kept; the offset never affects the response.
    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  txnid;
        logic [25:0] line;
    } slot_t;

    slot_t             slot_q  [QUEUE_DEPTH];
    logic [CW-1:0]     count_q [QUEUE_DEPTH];
    logic [IW:0]       wr_ptr;
    logic [IW:0]       rd_ptr;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic              rdy_en;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              legal_op;
    logic              offset_unused;
    slot_t             head;

    assign offset_unused = ^downstream_txreq_pld[5:0];

    assign wr_idx = wr_ptr[IW-1:0];
    assign rd_idx = rd_ptr[IW-1:0];
    assign full   = (wr_idx == rd_idx) && (wr_ptr[IW] != rd_ptr[IW]);
    assign empty  = (wr_ptr == rd_ptr);

    // A full queue stays not-ready even when the head pops on the same edge.
    assign downstream_txreq_rdy = rdy_en && !full;
    assign push = downstream_txreq_vld && downstream_txreq_rdy;

    assign head                 = slot_q[rd_idx];
    assign downstream_rxdat_vld = !empty && (count_q[rd_idx] == '0);
    assign pop                  = downstream_rxdat_vld && downstream_rxdat_rdy;

    assign legal_op = (downstream_txreq_pld[41:37] == 5'd1) ||
                      (downstream_txreq_pld[41:37] == 5'd3);

    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_idx] <= {downstream_txreq_pld[41:37],
                               downstream_txreq_pld[36:32],
                               downstream_txreq_pld[31:6]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rdy_en          <= 1'b0;
            outstanding_cnt <= '0;
            bad_opcode_err  <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   outstanding_cnt <= outstanding_cnt + OCC_ONE;
                2'b01:   outstanding_cnt <= outstanding_cnt - OCC_ONE;
                default: outstanding_cnt <= outstanding_cnt;
            endcase
            if (push && !legal_op) begin
                bad_opcode_err <= 1'b1;
            end
        end
    end

    // Free slots always hold zero, so saturating every nonzero count is the same as
    // counting only occupied slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (push && (wr_idx == IW'(i))) begin
                    count_q[i] <= LAT_LOAD;
                end else if (count_q[i] != '0) begin
                    count_q[i] <= count_q[i] - CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        downstream_rxdat_pld = '0;
        if (downstream_rxdat_vld) begin
            downstream_rxdat_pld[530:526] = head.opcode;
            downstream_rxdat_pld[525:521] = head.txnid;
            for (int w = 0; w < 16; w++) begin
                downstream_rxdat_pld[9 + 32*w +: 32] = {head.line, 2'b00, 4'(w)};
            end
            downstream_rxdat_pld[8:0] = {4'b0000, head.txnid};
        end
    end

endmodule

// File: tb/tb_icache_downstream_responder.sv
// Directed bench for icache_downstream_responder with an in-order scoreboard and
// a latency model checked on every response.
module tb_icache_downstream_responder;

    localparam int QD  = 4;
    localparam int LAT = 8;

    logic         clk;
    logic         rst_n;
    logic         txreq_vld;
    logic         txreq_rdy;
    logic [41:0]  txreq_pld;
    logic         rxdat_vld;
    logic         rxdat_rdy;
    logic [530:0] rxdat_pld;
    logic [2:0]   outstanding_cnt;
    logic         bad_opcode_err;

    int checks = 0;
    int errors = 0;

    icache_downstream_responder #(.QUEUE_DEPTH(QD), .LATENCY(LAT)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .downstream_txreq_vld (txreq_vld),
        .downstream_txreq_rdy (txreq_rdy),
        .downstream_txreq_pld (txreq_pld),
        .downstream_rxdat_vld (rxdat_vld),
        .downstream_rxdat_rdy (rxdat_rdy),
        .downstream_rxdat_pld (rxdat_pld),
        .outstanding_cnt      (outstanding_cnt),
        .bad_opcode_err       (bad_opcode_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [530:0] pld;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   last_pop = 0;
    bit   seen_head = 0;
    bit   stall_prev = 0;
    logic [530:0] pld_prev;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [530:0] obs, input logic [530:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [530:0] model(input logic [41:0] r);
        logic [530:0] p;
        p = '0;
        p[530:526] = r[41:37];
        p[525:521] = r[36:32];
        for (int w = 0; w < 16; w++) p[9 + 32*w +: 32] = {r[31:6], 2'b00, 4'(w)};
        p[8:0] = {4'b0000, r[36:32]};
        return p;
    endfunction

    // Response monitor: first-valid cycle = max(accept + LAT, previous pop edge).
    always @(negedge clk) begin
        if (!rst_n) begin
            seen_head  = 0;
            stall_prev = 0;
            last_pop   = 0;
        end else begin
            if (rxdat_vld) begin
                if (sb.size() == 0) begin
                    check("spurious_vld", rxdat_vld, 1'b0);
                end else begin
                    if (!seen_head) begin
                        int exp_first;
                        exp_first = (sb[0].acc + LAT > last_pop) ? sb[0].acc + LAT : last_pop;
                        check("latency", edge_cnt, exp_first);
                        seen_head = 1;
                    end
                    if (stall_prev) check("stall_hold", rxdat_pld, pld_prev);
                    if (rxdat_rdy) begin
                        check("rsp_pld", rxdat_pld, sb[0].pld);
                        void'(sb.pop_front());
                        last_pop  = edge_cnt + 1;
                        seen_head = 0;
                    end
                end
            end else if (stall_prev) begin
                check("stall_vld_drop", rxdat_vld, 1'b1);
            end
            if (txreq_vld && txreq_rdy) sb.push_back('{model(txreq_pld), edge_cnt + 1});
            stall_prev = rxdat_vld && !rxdat_rdy;
            pld_prev   = rxdat_pld;
        end
    end

    task automatic send(input logic [4:0] op, input logic [4:0] id, input logic [31:0] a);
        bit ok;
        ok = 0;
        txreq_vld = 1'b1;
        txreq_pld = {op, id, a};
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txreq_rdy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("send_timeout", txreq_rdy, 1'b1);
        @(posedge clk);
        #1;
        txreq_vld = 1'b0;
    endtask

    task automatic wait_vld(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rxdat_vld) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check(tag, rxdat_vld, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        txreq_vld = 1'b0;
        txreq_pld = '0;
        rxdat_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txreq_rdy", txreq_rdy, 1'b0);
        check("rst_rxdat_vld", rxdat_vld, 1'b0);
        check("rst_rxdat_pld", rxdat_pld, '0);
        check("rst_cnt", outstanding_cnt, 3'd0);
        check("rst_err", bad_opcode_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_before_first_edge", txreq_rdy, 1'b0);
        idle(1);
        check("rdy_after_first_edge", txreq_rdy, 1'b1);

        // Single request
        rxdat_rdy = 1'b1;
        send(5'd1, 5'd3, 32'h0001_2340);
        wait_vld("t1_vld_timeout");
        check("t1_word0", rxdat_pld[9 +: 32], 32'h0001_2340);
        check("t1_word15", rxdat_pld[9 + 32*15 +: 32], 32'h0001_234F);
        check("t1_entry_idx", rxdat_pld[8:0], 9'd3);
        check("t1_opcode", rxdat_pld[530:526], 5'd1);
        idle(2);
        check("t1_cnt_drained", outstanding_cnt, 3'd0);

        // Four back-to-back requests fill the queue
        send(5'd1, 5'd0, 32'h1000_0000);
        send(5'd3, 5'd1, 32'h2000_0040);
        send(5'd1, 5'd2, 32'h3000_0080);
        send(5'd1, 5'd3, 32'hFFFF_FFFF);
        check("t2_full_rdy", txreq_rdy, 1'b0);
        check("t2_full_cnt", outstanding_cnt, 3'd4);
        wait_vld("t2_vld_timeout");
        idle(1);
        check("t2_rdy_after_pop", txreq_rdy, 1'b1);
        idle(10);
        check("t2_cnt_drained", outstanding_cnt, 3'd0);

        // Backpressure with two queued
        rxdat_rdy = 1'b0;
        send(5'd3, 5'd7, 32'h0ABC_0100);
        send(5'd1, 5'd8, 32'h0ABC_0200);
        idle(20);
        check("t3_vld_held", rxdat_vld, 1'b1);
        check("t3_cnt", outstanding_cnt, 3'd2);
        rxdat_rdy = 1'b1;
        idle(2);
        check("t3_drained", outstanding_cnt, 3'd0);

        // Push and pop on the same edge
        rxdat_rdy = 1'b0;
        send(5'd1, 5'd9, 32'h0055_0000);
        send(5'd1, 5'd10, 32'h0066_0000);
        idle(10);
        check("t4_cnt_before", outstanding_cnt, 3'd2);
        check("t4_head_vld", rxdat_vld, 1'b1);
        rxdat_rdy = 1'b1;
        send(5'd3, 5'd11, 32'h0077_0000);
        rxdat_rdy = 1'b0;
        check("t4_cnt_after", outstanding_cnt, 3'd2);
        rxdat_rdy = 1'b1;
        idle(20);
        check("t4_drained", outstanding_cnt, 3'd0);

        // Illegal opcode is answered and flagged
        check("t5_err_before", bad_opcode_err, 1'b0);
        send(5'd5, 5'd12, 32'h0ABC_DEC0);
        check("t5_err_set", bad_opcode_err, 1'b1);
        wait_vld("t5_vld_timeout");
        check("t5_opcode_echo", rxdat_pld[530:526], 5'd5);
        idle(5);
        check("t5_err_sticky", bad_opcode_err, 1'b1);

        // Reset mid-countdown discards everything
        rxdat_rdy = 1'b0;
        send(5'd1, 5'd13, 32'h0100_0000);
        send(5'd1, 5'd14, 32'h0200_0000);
        send(5'd1, 5'd15, 32'h0300_0000);
        idle(3);
        check("t6_cnt_before", outstanding_cnt, 3'd3);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("t6_vld_in_rst", rxdat_vld, 1'b0);
        check("t6_cnt_in_rst", outstanding_cnt, 3'd0);
        check("t6_err_in_rst", bad_opcode_err, 1'b0);
        check("t6_rdy_in_rst", txreq_rdy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rxdat_rdy = 1'b1;
        idle(20);
        check("t6_vld_after", rxdat_vld, 1'b0);
        check("t6_cnt_after", outstanding_cnt, 3'd0);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
